uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. It adds configurable data width, oversample ratio, parity, 1 or 2 stop bits, an input synchroniser, and error/break reporting. It sits between the shared baud-tick generator and the RX FIFO or register interface. It consumes the oversampled bd_tick strobe and emits one ready pulse per received frame.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line
OVERSAMPLE, 16, bd_tick strobes per bit time, even, legal 8..32
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits expected, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous active-high
bd_tick  in  1  oversample strobe, one clk cycle wide, OVERSAMPLE per bit
rx  in  1  asynchronous serial line, idle high
ready  out  1  one-cycle pulse: frame complete, rd_data and flags valid
rd_data  out  DATA_BITS  received word, right-aligned, held until next ready
parity_err  out  1  parity mismatch on last frame, held until next ready
frame_err  out  1  any sampled stop bit was 0 on last frame, held until next ready
break_det  out  1  last frame was all-zero including parity and stop, held until next ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ready=0, rd_data=0, all flags 0, state=IDLE, counters 0. Both synchroniser flops reset to 1 so no false start occurs after reset.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s. Added latency is 2 clk.
- Counters: tick_cnt is wide enough for OVERSAMPLE-1. bit_cnt is wide enough for DATA_BITS. Both advance only on bd_tick.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: arm on a falling edge of rx_s (previous 1, current 0). A line held low never re-arms. Clear tick_cnt and go to START.
- START: on bd_tick at tick_cnt==OVERSAMPLE/2-1:
  - rx_s==0: go to DATA, clear tick_cnt and bit_cnt.
  - rx_s==1: glitch, return to IDLE with no output.
  - Otherwise tick_cnt++.
- DATA: on bd_tick at tick_cnt==OVERSAMPLE-1 (mid-bit), shift rx_s in at the MSB of the shift register (LSB-first reception), bit_cnt++, clear tick_cnt. After DATA_BITS samples, go to PARITY if PARITY_MODE!=0, else STOP.
- PARITY: sample at the same point. Odd mode: error if XOR(data, p)==0. Even mode: error if XOR(data, p)==1. Go to STOP.
- STOP: sample each stop bit at mid-bit. Any 0 sets a pending frame error. After STOP_BITS samples, complete the frame.
- Completion, in the same clk as the final stop sample's bd_tick, registered:
  - ready=1 for exactly one clk cycle.
  - rd_data, parity_err, frame_err and break_det update together.
  - Return to IDLE.
- Latency: ready rises 1 clk after the bd_tick at the middle of the last stop bit.
- break_det=1 requires data==0, parity bit 0 (if present), and all stop bits 0. break_det implies frame_err.
- No stop-bit resynchronisation. After a framing error, IDLE waits for rx_s to return high before re-arming.
- rx changes while bd_tick is low are ignored except for IDLE edge arming.
- rst asserted mid-frame aborts the frame: no ready pulse, and all outputs return to reset values on the next clk.
- Parameter values outside the legal ranges are a static error. The block stops elaboration via a generate-time check.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: every data, parity and stop bit is the 2-of-3 majority of rx_s sampled at tick_cnt OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1. The decision is made at OVERSAMPLE-1, so timing is unchanged. The START validation remains a single sample.
- Not defined: single sample at tick_cnt==OVERSAMPLE-1. The 2 extra sample flops and the vote logic are absent.

Test Plan:
- Defaults (8N1, OVERSAMPLE=16, bd_tick every 4 clk), send 0x55 -> exactly one ready pulse; rd_data=0x55; parity_err=frame_err=break_det=0.
- PARITY_MODE=2, DATA_BITS=8, send 0xA3 with parity bit 0 -> parity_err=0. Same data with parity bit 1 -> parity_err=1, rd_data=0xA3.
- STOP_BITS=2, send 0x3C with second stop bit 0 -> frame_err=1, rd_data=0x3C, break_det=0.
- Hold rx low for 12 bit times, then high -> one ready with rd_data=0x00, break_det=1 and frame_err=1. No second ready until a fresh 1->0 edge occurs.
- rx low pulse of 3 bd_tick periods -> START rejects it, no ready, state back to IDLE. A following valid 0x81 frame is received correctly.
- Assert rst for 1 clk during data bit 4 of a frame -> no ready and outputs 0. A subsequent 0xF0 frame is received correctly. With UART_RX_MAJORITY_EN, a 1-tick inverted glitch at tick_cnt==14 of bit 2 does not corrupt rd_data.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised oversampling UART receiver with parity,
// 1/2 stop bits, 2-flop input synchroniser and error/break reporting.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   bd_tick    oversample strobe, OVERSAMPLE pulses per bit time
//   rx         asynchronous serial line, idle high
//   ready      one-cycle pulse, frame complete
//   rd_data    received word, right-aligned, held until next ready
//   parity_err parity mismatch on last frame
//   frame_err  a stop bit sampled 0 on last frame
//   break_det  last frame all-zero including parity and stop bits
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority bit voting.
module uart_rx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bd_tick,
    input  logic                 rx,
    output logic                 ready,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);

    if (DATA_BITS < 5 || DATA_BITS > 9 ||
        OVERSAMPLE < 8 || OVERSAMPLE > 32 ||
        (OVERSAMPLE % 2) != 0 ||
        PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_rx_cfg: illegal parameter value");
    end

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_n;

    logic rx_m, rx_s, rx_d;

    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_acc, par_n;
    logic                 ferr_p, ferr_n;
    logic                 ones, ones_n;
    logic                 done;
    logic                 mid;
    logic                 bit_val;

    // Synchroniser and edge-history flops reset high so a line that is
    // idle at reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign mid = bd_tick && (tick_cnt == T_LAST);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] T_M3 = TW'(OVERSAMPLE - 3);
    localparam logic [TW-1:0] T_M2 = TW'(OVERSAMPLE - 2);

    logic maj_a, maj_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            maj_a <= 1'b0;
            maj_b <= 1'b0;
        end else if (bd_tick) begin
            if (tick_cnt == T_M3) maj_a <= rx_s;
            if (tick_cnt == T_M2) maj_b <= rx_s;
        end
    end

    // Third vote is the live sample taken at the decision tick.
    assign bit_val = (maj_a & maj_b) |
                     (maj_a & rx_s)  |
                     (maj_b & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            ferr_p   <= 1'b0;
            ones     <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            par_acc  <= par_n;
            ferr_p   <= ferr_n;
            ones     <= ones_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        par_n   = par_acc;
        ferr_n  = ferr_p;
        ones_n  = ones;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_d && !rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end
            START: begin
                if (bd_tick) begin
                    if (tick_cnt == T_HALF) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                            par_n   = 1'b0;
                            ferr_n  = 1'b0;
                            ones_n  = 1'b0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (mid) begin
                    shreg_n = {bit_val, shreg[DATA_BITS-1:1]};
                    par_n   = par_acc ^ bit_val;
                    ones_n  = ones | bit_val;
                    tick_n  = '0;
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == B_DATA) begin
                        bit_n   = '0;
                        state_n = (PARITY_MODE != 0) ? PARITY : STOP;
                    end
                end else if (bd_tick) begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (mid) begin
                    par_n   = par_acc ^ bit_val;
                    ones_n  = ones | bit_val;
                    tick_n  = '0;
                    bit_n   = '0;
                    state_n = STOP;
                end else if (bd_tick) begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            STOP: begin
                if (mid) begin
                    if (!bit_val) ferr_n = 1'b1;
                    ones_n = ones | bit_val;
                    tick_n = '0;
                    bit_n  = bit_cnt + 1'b1;
                    if (bit_cnt == B_STOP) begin
                        done    = 1'b1;
                        bit_n   = '0;
                        state_n = IDLE;
                    end
                end else if (bd_tick) begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // par_acc holds the XOR of data and parity bits: odd parity wants 1,
    // even parity wants 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready      <= 1'b0;
            rd_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            ready <= done;
            if (done) begin
                rd_data    <= shreg;
                frame_err  <= ferr_n;
                break_det  <= ~ones_n;
                parity_err <= (PARITY_MODE == 1) ? ~par_acc :
                              (PARITY_MODE == 2) ?  par_acc : 1'b0;
            end
        end
    end

endmodule
